sb_param_track: RTL

SB_PARAM_TRACK -- requirements
Module: sb_param_track

---
 rtl/sb_param_pkg.sv | 37 +++
 rtl/sb_track_mux.sv | 45 ++++
 rtl/sb_param_track.sv | 98 +++++++++
 3 files changed

// File: rtl/sb_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sb_param_pkg
// Description : Derived sizing helpers shared by the switch-block track logic.
// Revision    : 1.0 - initial release
// ============================================================================
package sb_param_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int calc_mux_in(input int num_pins);
        return 2 + num_pins;
    endfunction

    function automatic int calc_sel_w(input int num_pins);
        return clog2(calc_mux_in(num_pins));
    endfunction

    function automatic int calc_field_w(input int num_pins);
        return calc_sel_w(num_pins) + 1;
    endfunction

    function automatic int calc_cfg_len(input int chan_width, input int num_pins);
        return 2 * chan_width * calc_field_w(num_pins);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sb_track_mux.sv
`default_nettype none
// ============================================================================
// Module      : sb_track_mux
// Description : One output track: input select, out-of-range zeroing, optional
//               output flop chosen by the mode bit.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_track_mux #(
    parameter int MUX_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              enable,
    input  logic [SEL_W-1:0]  sel,
    input  logic              mode,
    input  logic [MUX_IN-1:0] mux_in,
    output logic              track_out
);

    logic w_mux;
    logic r_track;

    // Selects with no matching input fall through to the zero default.
    always_comb begin
        w_mux = 1'b0;
        for (int j = 0; j < MUX_IN; j++) begin
            if (enable && (sel == SEL_W'(j))) begin
                w_mux = mux_in[j];
            end
        end
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_track <= 1'b0;
        end else begin
            r_track <= w_mux;
        end
    end

    assign track_out = mode ? r_track : w_mux;

endmodule
`default_nettype wire

// File: rtl/sb_param_track.sv
`default_nettype none
// ============================================================================
// Module      : sb_param_track
// Description : Serially configured switch-block track routing with per-track
//               combinational or registered output mode.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_param_track
    import sb_param_pkg::*;
#(
    parameter int CHAN_WIDTH = 3,
    parameter int NUM_PINS   = 1
) (
    input  logic                  prog_clk,
    input  logic                  prog_rst_n,
    input  logic                  ccff_head,
    input  logic                  ccff_en,
    input  logic [CHAN_WIDTH-1:0] chanx_right_in,
    input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
    input  logic [NUM_PINS-1:0]   grid_pin_in,
    output logic [CHAN_WIDTH-1:0] chanx_right_out,
    output logic [CHAN_WIDTH-1:0] chany_bottom_out,
    output logic                  ccff_tail,
    output logic                  cfg_done
);

    localparam int c_mux_in  = calc_mux_in(NUM_PINS);
    localparam int c_sel_w   = calc_sel_w(NUM_PINS);
    localparam int c_field_w = calc_field_w(NUM_PINS);
    localparam int c_cfg_len = calc_cfg_len(CHAN_WIDTH, NUM_PINS);
    localparam int c_cnt_w   = clog2(c_cfg_len);

    logic [c_cfg_len-1:0] r_chain;
    logic [c_cfg_len-1:0] r_active;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_cfg_done;
    logic                 r_loaded;
    logic [c_cfg_len-1:0] w_chain_next;

    assign w_chain_next = {r_chain[c_cfg_len-2:0], ccff_head};

    // The completing shift commits the post-shift chain in the same edge.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_chain    <= '0;
            r_active   <= '0;
            r_count    <= '0;
            r_cfg_done <= 1'b0;
            r_loaded   <= 1'b0;
        end else if (ccff_en) begin
            r_chain <= w_chain_next;
            if (r_count == c_cnt_w'(c_cfg_len - 1)) begin
                r_active   <= w_chain_next;
                r_count    <= '0;
                r_cfg_done <= 1'b1;
                r_loaded   <= 1'b1;
            end else begin
                r_count    <= r_count + c_cnt_w'(1);
                r_cfg_done <= 1'b0;
            end
        end
    end

    assign ccff_tail = r_chain[c_cfg_len-1];
    assign cfg_done  = r_cfg_done;

    for (genvar i = 0; i < CHAN_WIDTH; i++) begin : g_chanx
        sb_track_mux #(
            .MUX_IN (c_mux_in),
            .SEL_W  (c_sel_w)
        ) u_mux (
            .prog_clk   (prog_clk),
            .prog_rst_n (prog_rst_n),
            .enable     (r_loaded),
            .sel        (r_active[i*c_field_w +: c_sel_w]),
            .mode       (r_active[i*c_field_w + c_sel_w]),
            .mux_in     ({grid_pin_in, chany_bottom_in[(i+1) % CHAN_WIDTH], chany_bottom_in[i]}),
            .track_out  (chanx_right_out[i])
        );
    end

    for (genvar i = 0; i < CHAN_WIDTH; i++) begin : g_chany
        sb_track_mux #(
            .MUX_IN (c_mux_in),
            .SEL_W  (c_sel_w)
        ) u_mux (
            .prog_clk   (prog_clk),
            .prog_rst_n (prog_rst_n),
            .enable     (r_loaded),
            .sel        (r_active[(CHAN_WIDTH+i)*c_field_w +: c_sel_w]),
            .mode       (r_active[(CHAN_WIDTH+i)*c_field_w + c_sel_w]),
            .mux_in     ({grid_pin_in, chanx_right_in[(i+1) % CHAN_WIDTH], chanx_right_in[i]}),
            .track_out  (chany_bottom_out[i])
        );
    end

endmodule
`default_nettype wire
